// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencer: the controller state encoding
// and the helper that sizes the MAC array result bus.
package mac_pkg;

  // Controller states. IDLE is the only state in which BUSY is low.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } mac_state_e;

  // Width of one MAC array result: the product of two operands plus
  // enough headroom to add ATOMIC_C lane products without overflow.
  function automatic int mac_w(input int atomic_c, input int bitwidth);
    return 2 * bitwidth + $clog2(atomic_c);
  endfunction

endpackage

// File: rtl/mac_seq.sv
// MAC sequencer: reads CFG_LEN operand chunks from a buffer starting at
// CFG_BASE, counts the results that come back from the MAC array and
// accumulates them into one dot product. The result is offered with a
// valid/ready handshake. Any result arriving when none is outstanding
// sets a sticky error flag and is not accumulated.
module mac_seq
  import mac_pkg::*;
#(
  parameter int ATOMIC_C   = 4,
  parameter int BITWIDTH   = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                                   CLK,
  input  logic                                   NRST,
  input  logic                                   CFG_START,
  input  logic [ADDR_WIDTH-1:0]                  CFG_BASE,
  input  logic [CNT_WIDTH-1:0]                   CFG_LEN,
  output logic                                   BUF_RD_EN,
  output logic [ADDR_WIDTH-1:0]                  BUF_RD_ADDR,
  output logic                                   MAC_VALID_IN,
  input  logic [mac_w(ATOMIC_C, BITWIDTH)-1:0]   MAC_RES,
  input  logic                                   MAC_VALID_OUT,
  output logic [ACC_WIDTH-1:0]                   OUT_DATA,
  output logic                                   OUT_VALID,
  input  logic                                   OUT_READY,
  output logic                                   BUSY,
  output logic                                   ERR
);

  // Counters carry one extra bit so the largest job length and the final
  // count value never alias each other.
  localparam int CW = CNT_WIDTH + 1;

  mac_state_e            state;
  mac_state_e            state_nx;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CW-1:0]         len_q;
  logic [CW-1:0]         issue_cnt;
  logic [CW-1:0]         recv_cnt;
  logic [ACC_WIDTH-1:0]  acc;
  logic                  mac_valid_q;
  logic                  err_q;

  logic                  start_acc;
  logic                  issue_last;
  logic                  recv_done;
  logic                  res_accept;
  logic                  res_bad;

  // A start is only honoured from IDLE; elsewhere it is simply not seen.
  assign start_acc  = (state == IDLE) && CFG_START;
  assign issue_last = (issue_cnt == (len_q - CW'(1)));
  assign recv_done  = (recv_cnt == len_q);

  // A result is legal only while a job is in flight and still owes results.
  assign res_accept = MAC_VALID_OUT && ((state == ISSUE) || (state == DRAIN)) && !recv_done;
  assign res_bad    = MAC_VALID_OUT && !res_accept;

  // State register.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: issue reads, wait for every result, then hand off.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (CFG_START) begin
          state_nx = (CFG_LEN != '0) ? ISSUE : OUTPUT;
        end
      end
      ISSUE: begin
        if (issue_last) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (recv_done) begin
          state_nx = OUTPUT;
        end
      end
      OUTPUT: begin
        if (OUT_READY) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Job configuration is captured once, at the accepted start.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      base_q <= '0;
      len_q  <= '0;
    end else if (start_acc) begin
      base_q <= CFG_BASE;
      len_q  <= CW'(CFG_LEN);
    end
  end

  // Issue counter: one buffer read per ISSUE cycle.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      issue_cnt <= '0;
    end else if (start_acc) begin
      issue_cnt <= '0;
    end else if (state == ISSUE) begin
      issue_cnt <= issue_cnt + CW'(1);
    end
  end

  // Receive counter and accumulator advance only on legal MAC results.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      recv_cnt <= '0;
      acc      <= '0;
    end else if (start_acc) begin
      recv_cnt <= '0;
      acc      <= '0;
    end else if (res_accept) begin
      recv_cnt <= recv_cnt + CW'(1);
      acc      <= acc + ACC_WIDTH'(MAC_RES);
    end
  end

  // Buffer data lands one cycle after the read, so the MAC valid follows it.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      mac_valid_q <= 1'b0;
    end else begin
      mac_valid_q <= BUF_RD_EN;
    end
  end

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      err_q <= 1'b0;
    end else if (res_bad) begin
      err_q <= 1'b1;
    end
  end

  assign BUF_RD_EN    = (state == ISSUE);
  assign BUF_RD_ADDR  = base_q + ADDR_WIDTH'(issue_cnt);
  assign MAC_VALID_IN = mac_valid_q;
  assign OUT_DATA     = acc;
  assign OUT_VALID    = (state == OUTPUT);
  assign BUSY         = (state != IDLE);
  assign ERR          = err_q;

endmodule

// File: tb/tb_mac_seq.sv
// Self-checking bench for mac_seq. A behavioural MAC array model returns
// one result per MAC_VALID_IN after a programmable latency; expected sums
// and read addresses are computed directly from the job parameters.
module tb_mac_seq;

  localparam int MAC_W = 18;

  logic        CLK;
  logic        NRST;
  logic        CFG_START;
  logic [9:0]  CFG_BASE;
  logic [7:0]  CFG_LEN;
  logic        BUF_RD_EN;
  logic [9:0]  BUF_RD_ADDR;
  logic        MAC_VALID_IN;
  logic [MAC_W-1:0] MAC_RES = '0;
  logic        MAC_VALID_OUT = 1'b0;
  logic [31:0] OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        BUSY;
  logic        ERR;

  int checks   = 0;
  int failures = 0;

  int          cyc     = 0;
  int          mac_lat = 2;
  int unsigned res_vals[$];
  int          pend_due[$];
  int unsigned pend_val[$];
  logic [9:0]  rd_addrs[$];
  int          rd_cyc[$];
  int          ov_seen = 0;
  bit          inject_en = 0;
  int unsigned inject_val = 0;

  mac_seq dut (
    .CLK          (CLK),
    .NRST         (NRST),
    .CFG_START    (CFG_START),
    .CFG_BASE     (CFG_BASE),
    .CFG_LEN      (CFG_LEN),
    .BUF_RD_EN    (BUF_RD_EN),
    .BUF_RD_ADDR  (BUF_RD_ADDR),
    .MAC_VALID_IN (MAC_VALID_IN),
    .MAC_RES      (MAC_RES),
    .MAC_VALID_OUT(MAC_VALID_OUT),
    .OUT_DATA     (OUT_DATA),
    .OUT_VALID    (OUT_VALID),
    .OUT_READY    (OUT_READY),
    .BUSY         (BUSY),
    .ERR          (ERR)
  );

  // Free-running clock, period 10.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // MAC array and buffer observer, evaluated on the falling edge.
  always @(negedge CLK) begin
    int unsigned v;
    cyc = cyc + 1;
    if (!NRST) begin
      pend_due.delete();
      pend_val.delete();
      MAC_VALID_OUT = 1'b0;
      MAC_RES       = '0;
    end else begin
      if (BUF_RD_EN) begin
        rd_addrs.push_back(BUF_RD_ADDR);
        rd_cyc.push_back(cyc);
      end
      if (OUT_VALID) ov_seen++;
      if (MAC_VALID_IN) begin
        v = (res_vals.size() > 0) ? res_vals.pop_front() : 0;
        pend_due.push_back(cyc + mac_lat);
        pend_val.push_back(v);
      end
      if (inject_en) begin
        MAC_VALID_OUT = 1'b1;
        MAC_RES       = MAC_W'(inject_val);
        inject_en     = 0;
      end else if (pend_due.size() > 0 && pend_due[0] == cyc) begin
        MAC_VALID_OUT = 1'b1;
        MAC_RES       = MAC_W'(pend_val.pop_front());
        void'(pend_due.pop_front());
      end else begin
        MAC_VALID_OUT = 1'b0;
      end
    end
  end

  // Load n random results for the MAC model and return their wrapped sum.
  function automatic longint unsigned fill_vals(input int n);
    longint unsigned s = 0;
    int unsigned v;
    res_vals.delete();
    for (int i = 0; i < n; i++) begin
      v = $urandom_range(0, (1 << MAC_W) - 1);
      res_vals.push_back(v);
      s += v;
    end
    return s & 64'hFFFF_FFFF;
  endfunction

  task automatic start_job(input logic [9:0] b, input int l);
    rd_addrs.delete();
    rd_cyc.delete();
    @(negedge CLK);
    CFG_BASE  = b;
    CFG_LEN   = 8'(l);
    CFG_START = 1'b1;
    @(negedge CLK);
    CFG_START = 1'b0;
  endtask

  task automatic wait_out(input int limit, output bit ok, output int waited);
    waited = 0;
    while (!OUT_VALID && waited < limit) begin
      @(negedge CLK);
      waited++;
    end
    ok = OUT_VALID;
  endtask

  task automatic handshake;
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
  endtask

  task automatic test_reset;
    NRST = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({BUF_RD_EN, BUF_RD_ADDR, MAC_VALID_IN, OUT_VALID, BUSY, ERR} !== 15'd0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl got en=%b addr=%h mvi=%b ov=%b busy=%b err=%b exp all 0",
               BUF_RD_EN, BUF_RD_ADDR, MAC_VALID_IN, OUT_VALID, BUSY, ERR);
    end
    checks++;
    if (OUT_DATA !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_data got=%h exp=0", OUT_DATA);
    end
    NRST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_basic;
    bit ok;
    int w;
    res_vals = '{5, 7, 9};
    mac_lat  = 2;
    start_job(10'h010, 3);
    wait_out(100, ok, w);
    checks++;
    if (!ok || OUT_DATA !== 32'd21) begin
      failures++;
      $display("[TB] FAIL basic_sum got valid=%b data=%0d exp valid=1 data=21", ok, OUT_DATA);
    end
    checks++;
    if (rd_addrs.size() != 3 || rd_addrs[0] !== 10'h010 || rd_addrs[1] !== 10'h011 ||
        rd_addrs[2] !== 10'h012 || rd_cyc[1] != rd_cyc[0] + 1 || rd_cyc[2] != rd_cyc[0] + 2) begin
      failures++;
      $display("[TB] FAIL basic_reads got count=%0d exp 3 consecutive reads 010..012", rd_addrs.size());
    end
    checks++;
    if (BUSY !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_busy_hold got=%b exp=1", BUSY);
    end
    handshake();
    checks++;
    if (BUSY !== 1'b0 || OUT_VALID !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_busy_fall got busy=%b ov=%b exp 0 0", BUSY, OUT_VALID);
    end
  endtask

  task automatic test_zero_len;
    bit ok;
    int w;
    res_vals.delete();
    start_job(10'h123, 0);
    wait_out(10, ok, w);
    checks++;
    if (!ok || w > 1 || OUT_DATA !== 32'd0) begin
      failures++;
      $display("[TB] FAIL zero_len_out got valid=%b extra_wait=%0d data=%0d exp valid=1 wait<=1 data=0",
               ok, w, OUT_DATA);
    end
    checks++;
    if (rd_addrs.size() != 0) begin
      failures++;
      $display("[TB] FAIL zero_len_reads got=%0d exp=0", rd_addrs.size());
    end
    handshake();
  endtask

  task automatic test_backpressure;
    bit ok;
    int w;
    longint unsigned exp;
    exp     = fill_vals(5);
    mac_lat = 3;
    start_job(10'h040, 5);
    wait_out(100, ok, w);
    checks++;
    if (!ok || OUT_DATA !== exp[31:0]) begin
      failures++;
      $display("[TB] FAIL bp_sum got valid=%b data=%h exp=%h", ok, OUT_DATA, exp[31:0]);
    end
    rd_addrs.delete();
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin
        CFG_BASE  = 10'h200;
        CFG_LEN   = 8'd3;
        CFG_START = 1'b1;
      end
      if (k == 5) CFG_START = 1'b0;
      @(negedge CLK);
      checks++;
      if (OUT_VALID !== 1'b1 || OUT_DATA !== exp[31:0]) begin
        failures++;
        $display("[TB] FAIL bp_hold_%0d got valid=%b data=%h exp valid=1 data=%h",
                 k, OUT_VALID, OUT_DATA, exp[31:0]);
      end
    end
    handshake();
    ov_seen = 0;
    repeat (5) @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0 || rd_addrs.size() != 0 || ov_seen != 0) begin
      failures++;
      $display("[TB] FAIL bp_no_restart got busy=%b reads=%0d ov=%0d exp 0 0 0",
               BUSY, rd_addrs.size(), ov_seen);
    end
  endtask

  task automatic test_wrap;
    bit ok;
    int w;
    longint unsigned exp;
    exp     = fill_vals(4);
    mac_lat = 1;
    start_job(10'h3FE, 4);
    wait_out(100, ok, w);
    checks++;
    if (rd_addrs.size() != 4 || rd_addrs[0] !== 10'h3FE || rd_addrs[1] !== 10'h3FF ||
        rd_addrs[2] !== 10'h000 || rd_addrs[3] !== 10'h001) begin
      failures++;
      $display("[TB] FAIL wrap_addr got count=%0d first=%h exp 3FE,3FF,000,001",
               rd_addrs.size(), (rd_addrs.size() > 0) ? rd_addrs[0] : 10'h0);
    end
    checks++;
    if (!ok || OUT_DATA !== exp[31:0]) begin
      failures++;
      $display("[TB] FAIL wrap_sum got valid=%b data=%h exp=%h", ok, OUT_DATA, exp[31:0]);
    end
    handshake();
  endtask

  task automatic test_random;
    bit ok;
    int w;
    int len;
    int bad;
    logic [9:0] b;
    longint unsigned exp;
    for (int j = 0; j < 6; j++) begin
      len     = $urandom_range(1, 20);
      b       = 10'($urandom_range(0, 1023));
      mac_lat = $urandom_range(1, 5);
      exp     = fill_vals(len);
      start_job(b, len);
      wait_out(200, ok, w);
      checks++;
      if (!ok || OUT_DATA !== exp[31:0]) begin
        failures++;
        $display("[TB] FAIL rand_sum_%0d got valid=%b data=%h exp=%h", j, ok, OUT_DATA, exp[31:0]);
      end
      bad = (rd_addrs.size() != len) ? 1 : 0;
      for (int i = 0; i < rd_addrs.size() && bad == 0; i++) begin
        if (rd_addrs[i] !== 10'(b + i) || rd_cyc[i] != rd_cyc[0] + i) bad = 1;
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("[TB] FAIL rand_reads_%0d got count=%0d exp %0d consecutive from %h",
                 j, rd_addrs.size(), len, b);
      end
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      handshake();
    end
    checks++;
    if (ERR !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rand_no_err got=%b exp=0", ERR);
    end
  endtask

  task automatic test_reset_mid_job;
    bit ok;
    int w;
    int n;
    longint unsigned exp;
    exp     = fill_vals(8);
    mac_lat = 3;
    ov_seen = 0;
    start_job(10'h080, 8);
    n = 0;
    while (rd_addrs.size() < 8 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b1 || BUF_RD_EN !== 1'b0 || OUT_VALID !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_in_drain got busy=%b rd=%b ov=%b exp 1 0 0", BUSY, BUF_RD_EN, OUT_VALID);
    end
    NRST = 1'b0;
    @(negedge CLK);
    checks++;
    if ({BUF_RD_EN, BUF_RD_ADDR, MAC_VALID_IN, OUT_VALID, BUSY, ERR} !== 15'd0 || OUT_DATA !== 32'd0) begin
      failures++;
      $display("[TB] FAIL mid_reset_outs got en=%b addr=%h mvi=%b ov=%b busy=%b err=%b data=%h exp all 0",
               BUF_RD_EN, BUF_RD_ADDR, MAC_VALID_IN, OUT_VALID, BUSY, ERR, OUT_DATA);
    end
    @(negedge CLK);
    NRST = 1'b1;
    repeat (4) @(negedge CLK);
    checks++;
    if (ov_seen != 0 || BUSY !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_abort got ov_seen=%0d busy=%b exp 0 0", ov_seen, BUSY);
    end
    exp = fill_vals(1);
    start_job(10'h001, 1);
    wait_out(100, ok, w);
    checks++;
    if (!ok || OUT_DATA !== exp[31:0]) begin
      failures++;
      $display("[TB] FAIL mid_followup got valid=%b data=%h exp=%h", ok, OUT_DATA, exp[31:0]);
    end
    handshake();
  endtask

  task automatic test_protocol_err;
    bit ok;
    int w;
    logic [31:0] prev;
    longint unsigned exp;
    prev       = OUT_DATA;
    inject_val = 32'h1_2345;
    inject_en  = 1;
    repeat (3) @(negedge CLK);
    checks++;
    if (ERR !== 1'b1) begin
      failures++;
      $display("[TB] FAIL err_set got=%b exp=1", ERR);
    end
    checks++;
    if (OUT_DATA !== prev) begin
      failures++;
      $display("[TB] FAIL err_no_acc got=%h exp=%h", OUT_DATA, prev);
    end
    repeat (5) @(negedge CLK);
    exp     = fill_vals(2);
    mac_lat = 2;
    start_job(10'h100, 2);
    wait_out(100, ok, w);
    checks++;
    if (!ok || OUT_DATA !== exp[31:0] || ERR !== 1'b1) begin
      failures++;
      $display("[TB] FAIL err_sticky got valid=%b data=%h err=%b exp valid=1 data=%h err=1",
               ok, OUT_DATA, ERR, exp[31:0]);
    end
    handshake();
  endtask

  initial begin
    NRST      = 1'b0;
    CFG_START = 1'b0;
    CFG_BASE  = '0;
    CFG_LEN   = '0;
    OUT_READY = 1'b0;
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_wrap();
    test_random();
    test_reset_mid_job();
    test_protocol_err();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
